instr_encoder: RTL and testbench

Sequential MIPS instruction encoder and loader: accepts one symbolic instruction per valid/ready handshake, packs it into a 32-bit machine word matching the single-cycle controller's opcode/funct map, buffers it in a small FIFO, and streams words into instruction memory through a write-port handshake at consecutive word addresses. It sits between the testbench/boot source and the instruction memory and produces exactly the `op`/`funct` encodings that the main and ALU decoders consume.

---
 rtl/instr_encoder.sv | 226 ++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS instructions into 32-bit machine words,
// buffers them in a DEPTH-entry FIFO and streams them into instruction memory
// at consecutive word addresses through a we/ready write port.
// Optional feature macro: DELAY_SLOT_PAD_EN -- when defined, a NOP word is
// written after every BEQ and J (branch delay slot padding).
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_val,
  input  logic              clear_err,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err,
  output logic [15:0]       wr_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef DELAY_SLOT_PAD_EN
  typedef enum logic [1:0] {IDLE, WRITE, PAD} state_t;
`else
  typedef enum logic [0:0] {IDLE, WRITE} state_t;
`endif

  state_t          state;

  // FIFO storage and control
  logic [31:0]     word_mem [DEPTH];
`ifdef DELAY_SLOT_PAD_EN
  logic            pad_mem  [DEPTH];
`endif
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;

  logic [32:0]     enc;        // {legal, word}
  logic            accept;
  logic            push;
  logic            bad;
  logic            pop;
  logic            done;
  logic [CW-1:0]   remain;
  logic [PW-1:0]   head_idx;
  logic [31:0]     next_word;
  logic            have_next;

  // Opcode/funct map shared with the single-cycle controller decoders.
  // Bit 32 flags a legal mnemonic; illegal ones return all zeros.
  function automatic logic [32:0] encode(
    input logic [3:0]  m,
    input logic [4:0]  s,
    input logic [4:0]  t,
    input logic [4:0]  d,
    input logic [15:0] i,
    input logic [25:0] tg
  );
    logic [32:0] r;
    r = {1'b1, 32'h0000_0000};
    case (m)
      4'd0:    r[31:0] = {6'h00, s, t, d, 5'd0, 6'h20};  // ADD
      4'd1:    r[31:0] = {6'h00, s, t, d, 5'd0, 6'h22};  // SUB
      4'd2:    r[31:0] = {6'h00, s, t, d, 5'd0, 6'h24};  // AND
      4'd3:    r[31:0] = {6'h00, s, t, d, 5'd0, 6'h25};  // OR
      4'd4:    r[31:0] = {6'h00, s, t, d, 5'd0, 6'h2A};  // SLT
      4'd5:    r[31:0] = {6'h23, s, t, i};               // LW
      4'd6:    r[31:0] = {6'h2B, s, t, i};               // SW
      4'd7:    r[31:0] = {6'h04, s, t, i};               // BEQ
      4'd8:    r[31:0] = {6'h08, s, t, i};               // ADDI
      4'd9:    r[31:0] = {6'h0F, 5'd0, t, i};            // LUI ignores rs
      4'd10:   r[31:0] = {6'h0D, s, t, i};               // ORI
      4'd11:   r[31:0] = {6'h02, tg};                    // J
      default: r       = '0;
    endcase
    return r;
  endfunction

`ifdef DELAY_SLOT_PAD_EN
  // Branches and jumps get a NOP in their delay slot.
  function automatic logic is_branch(input logic [3:0] m);
    return (m == 4'd7) || (m == 4'd11);
  endfunction
`endif

  assign enc      = encode(mnem, rs, rt, rd, imm, target);
  assign in_ready = (count < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc[32];
  assign bad      = accept && !enc[32];
  assign pop      = (state == WRITE) && mem_ready;
  assign done     = mem_we && mem_ready;

  // Entries still stored after this edge's pop (excluding any push), and the
  // index of the entry that becomes the head.
  assign remain    = count - CW'(pop);
  assign head_idx  = rptr + PW'(pop);
  assign have_next = (remain != '0) || push;

  // Next word to present: the oldest stored entry, or the word being pushed
  // right now when nothing else is buffered (gives one-cycle latency).
  always_comb begin
    next_word = enc[31:0];
    if (remain != '0) begin
      next_word = word_mem[head_idx];
    end
  end

  // FIFO data storage; payload only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wptr] <= enc[31:0];
`ifdef DELAY_SLOT_PAD_EN
      pad_mem[wptr]  <= is_branch(mnem);
`endif
    end
  end

  // FIFO pointers, occupancy and the sticky illegal-mnemonic flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      if (bad) begin
        err <= 1'b1;
      end else if (clear_err) begin
        err <= 1'b0;
      end
    end
  end

  // Write address and completed-write counter; addr_load overrides increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
      wr_count <= '0;
    end else begin
      if (addr_load) begin
        mem_addr <= addr_val;
      end else if (done) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      wr_count <= wr_count + 16'(done);
    end
  end

  // Write FSM with registered mem_we/mem_wdata; data holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (have_next) begin
            state     <= WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= next_word;
          end
        end
        WRITE: begin
          if (mem_ready) begin
`ifdef DELAY_SLOT_PAD_EN
            if (pad_mem[rptr]) begin
              state     <= PAD;
              mem_we    <= 1'b1;
              mem_wdata <= 32'h0000_0000;
            end else
`endif
            if (have_next) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= next_word;
            end else begin
              state     <= IDLE;
              mem_we    <= 1'b0;
            end
          end
        end
`ifdef DELAY_SLOT_PAD_EN
        PAD: begin
          if (mem_ready) begin
            if (have_next) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= next_word;
            end else begin
              state     <= IDLE;
              mem_we    <= 1'b0;
            end
          end
        end
`endif
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a randomized
// stream compared against a table-driven reference encoder and write log.
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_val;
  logic              clear_err;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              err;
  logic [15:0]       wr_count;

  int checks = 0;
  int errors = 0;

  // Log of every memory write, captured mid-cycle before its completing edge
  int          cap_addr[$];
  logic [31:0] cap_data[$];

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mnem      (mnem),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .imm       (imm),
    .target    (target),
    .addr_load (addr_load),
    .addr_val  (addr_val),
    .clear_err (clear_err),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .err       (err),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
      cap_addr.push_back(int'(mem_addr));
      cap_data.push_back(mem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference encoder: instruction fields placed by arithmetic from the
  // opcode/funct tables.
  function automatic logic [31:0] ref_word(int m, int s, int t, int d, int im, int tg);
    longint v;
    int fn_tab[5] = '{32, 34, 36, 37, 42};
    int op_tab[6] = '{35, 43, 4, 8, 15, 13};
    if (m < 5)       v = longint'(s) * (1 << 21) + longint'(t) * (1 << 16) + longint'(d) * (1 << 11) + fn_tab[m];
    else if (m == 9) v = longint'(15) * (1 << 26) + longint'(t) * (1 << 16) + im;
    else if (m < 11) v = longint'(op_tab[m-5]) * (1 << 26) + longint'(s) * (1 << 21) + longint'(t) * (1 << 16) + im;
    else             v = longint'(2) * (1 << 26) + tg;
    return v[31:0];
  endfunction

  task automatic reset_dut();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    mnem      = '0;
    rs        = '0;
    rt        = '0;
    rd        = '0;
    imm       = '0;
    target    = '0;
    addr_load = 1'b0;
    addr_val  = '0;
    clear_err = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cap_addr.delete();
    cap_data.delete();
  endtask

  // Wait (bounded) for in_ready, then complete the handshake on the next edge
  task automatic handshake();
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
    mnem = m; rs = s; rt = t; rd = d; imm = im; target = tg;
    in_valid = 1'b1;
    handshake();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 6'd0)   begin errors++; $display("FAIL rst_mem_addr got %0d want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (wr_count !== 16'd0)  begin errors++; $display("FAIL rst_wr_count got %0d want 0", wr_count); end
  endtask

  task automatic test_add();
    reset_dut();
    mem_ready = 1'b1;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    checks++; if (mem_we !== 1'b1)             begin errors++; $display("FAIL add_we got %b want 1", mem_we); end
    checks++; if (mem_addr !== 6'd0)           begin errors++; $display("FAIL add_addr got %0d want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0022_1820) begin errors++; $display("FAIL add_data got %h want 00221820", mem_wdata); end
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL add_we_after got %b want 0", mem_we); end
    checks++; if (wr_count !== 16'd1)  begin errors++; $display("FAIL add_wr_count got %0d want 1", wr_count); end
    checks++; if (mem_addr !== 6'd1)   begin errors++; $display("FAIL add_next_addr got %0d want 1", mem_addr); end
  endtask

  task automatic test_stall();
    reset_dut();
    mem_ready = 1'b0;
    send(4'd5, 5'd0, 5'd2, 5'd0, 16'h0050, 26'h0);
    send(4'd6, 5'd0, 5'd2, 5'd0, 16'h0054, 26'h0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 6'd0 || mem_wdata !== 32'h8C02_0050) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got we=%b addr=%0d data=%h want 1/0/8c020050", i, mem_we, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (cap_data.size() !== 2) begin
      errors++; $display("FAIL stall_count got %0d want 2", cap_data.size());
    end else begin
      checks++;
      if (cap_addr[0] != 0 || cap_data[0] !== 32'h8C02_0050) begin
        errors++; $display("FAIL stall_w0 got %0d/%h want 0/8c020050", cap_addr[0], cap_data[0]);
      end
      checks++;
      if (cap_addr[1] != 1 || cap_data[1] !== 32'hAC02_0054) begin
        errors++; $display("FAIL stall_w1 got %0d/%h want 1/ac020054", cap_addr[1], cap_data[1]);
      end
    end
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL stall_wr_count got %0d want 2", wr_count); end
  endtask

  task automatic test_full();
    logic [31:0] exp_w[$];
    logic [4:0]  s, t, d;
    reset_dut();
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
      exp_w.push_back(ref_word(i % 5, s, t, d, 0, 0));
      send(4'(i % 5), s, t, d, 16'h0, 26'h0);
      checks++;
      if (in_ready !== ((i + 1) < DEPTH)) begin
        errors++; $display("FAIL full_in_ready after %0d got %b", i + 1, in_ready);
      end
    end
    s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
    exp_w.push_back(ref_word(2, s, t, d, 0, 0));
    mnem = 4'd2; rs = s; rt = t; rd = d;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || mem_wdata !== exp_w[0]) begin
        errors++; $display("FAIL full_blocked cyc %0d got rdy=%b data=%h want 0/%h", i, in_ready, mem_wdata, exp_w[0]);
      end
    end
    mem_ready = 1'b1;
    handshake();
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (cap_data.size() != exp_w.size()) begin
      errors++; $display("FAIL full_count got %0d want %0d", cap_data.size(), exp_w.size());
    end else begin
      for (int i = 0; i < exp_w.size(); i++) begin
        checks++;
        if (cap_addr[i] != i || cap_data[i] !== exp_w[i]) begin
          errors++; $display("FAIL full_w%0d got %0d/%h want %0d/%h", i, cap_addr[i], cap_data[i], i, exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    mem_ready = 1'b1;
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'h0001, 26'h0);
    send(4'd8, 5'd1, 5'd3, 5'd0, 16'h0002, 26'h0);
    send(4'd8, 5'd1, 5'd4, 5'd0, 16'h0003, 26'h0);
    @(posedge clk); #1;
    checks++;
    if (cap_data.size() != 3) begin
      errors++; $display("FAIL b2b_rate got %0d writes want 3", cap_data.size());
    end
    checks++;
    if (cap_data.size() == 3 && cap_data[2] !== ref_word(8, 1, 4, 0, 3, 0)) begin
      errors++; $display("FAIL b2b_last got %h want %h", cap_data[2], ref_word(8, 1, 4, 0, 3, 0));
    end
  endtask

  task automatic test_branch();
    reset_dut();
    mem_ready = 1'b1;
    send(4'd7, 5'd4, 5'd5, 5'd0, 16'hFFFE, 26'h0);
    send(4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
    repeat (8) @(posedge clk);
    #1;
`ifdef DELAY_SLOT_PAD_EN
    checks++;
    if (cap_data.size() != 4) begin
      errors++; $display("FAIL br_count got %0d want 4", cap_data.size());
    end else begin
      checks++;
      if (cap_addr[0] != 0 || cap_data[0] !== 32'h1085_FFFE || cap_addr[1] != 1 || cap_data[1] !== 32'h0 ||
          cap_addr[2] != 2 || cap_data[2] !== 32'h0800_0010 || cap_addr[3] != 3 || cap_data[3] !== 32'h0) begin
        errors++; $display("FAIL br_words got %h %h %h %h want 1085fffe 0 08000010 0", cap_data[0], cap_data[1], cap_data[2], cap_data[3]);
      end
    end
    checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL br_wr_count got %0d want 4", wr_count); end
`else
    checks++;
    if (cap_data.size() != 2) begin
      errors++; $display("FAIL br_count got %0d want 2", cap_data.size());
    end else begin
      checks++;
      if (cap_addr[0] != 0 || cap_data[0] !== 32'h1085_FFFE || cap_addr[1] != 1 || cap_data[1] !== 32'h0800_0010) begin
        errors++; $display("FAIL br_words got %h %h want 1085fffe 08000010", cap_data[0], cap_data[1]);
      end
    end
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL br_wr_count got %0d want 2", wr_count); end
`endif
  endtask

  task automatic test_err();
    reset_dut();
    mem_ready = 1'b1;
    send(4'd14, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    checks++; if (err !== 1'b1)    begin errors++; $display("FAIL err_set got %b want 1", err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL err_no_we got %b want 0", mem_we); end
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b0 || wr_count !== 16'd0) begin errors++; $display("FAIL err_no_write got we=%b cnt=%0d want 0/0", mem_we, wr_count); end
    mnem = 4'd15; in_valid = 1'b1; clear_err = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b want 1", err); end
    @(posedge clk); #1;
    clear_err = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
  endtask

  task automatic test_wrap_reset();
    reset_dut();
    mem_ready = 1'b1;
    addr_load = 1'b1; addr_val = 6'd63;
    @(posedge clk); #1;
    addr_load = 1'b0;
    checks++; if (mem_addr !== 6'd63) begin errors++; $display("FAIL wrap_load got %0d want 63", mem_addr); end
    send(4'd8, 5'd0, 5'd8, 5'd0, 16'h0005, 26'h0);
    send(4'd10, 5'd8, 5'd9, 5'd0, 16'h00FF, 26'h0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (cap_data.size() != 2) begin
      errors++; $display("FAIL wrap_count got %0d want 2", cap_data.size());
    end else begin
      checks++;
      if (cap_addr[0] != 63 || cap_data[0] !== 32'h2008_0005 || cap_addr[1] != 0 || cap_data[1] !== 32'h3509_00FF) begin
        errors++; $display("FAIL wrap_words got %0d/%h %0d/%h want 63/20080005 0/350900ff", cap_addr[0], cap_data[0], cap_addr[1], cap_data[1]);
      end
    end
    mem_ready = 1'b0;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    checks++; if (mem_we !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL midrst_pre got we=%b err=%b want 1/1", mem_we, err); end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_wdata !== 32'h0 || err !== 1'b0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_outputs got rdy=%b we=%b addr=%0d data=%h err=%b cnt=%0d want 1/0/0/0/0/0",
               in_ready, mem_we, mem_addr, mem_wdata, err, wr_count);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cap_addr.delete();
    cap_data.delete();
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (mem_we !== 1'b0 || cap_data.size() != 0 || wr_count !== 16'd0) begin
      errors++; $display("FAIL midrst_dropped got we=%b writes=%0d cnt=%0d want 0/0/0", mem_we, cap_data.size(), wr_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_w[$];
    bit          exp_p[$];
    int  acc = 0, popped = 0, seen = 0, n = 0;
    bit  any_bad = 0;
    int  m, s, t, d, im, tg;
    reset_dut();
    for (int cyc = 0; cyc < 400; cyc++) begin
      while (seen < cap_data.size()) begin
        checks++;
        if (seen >= exp_w.size()) begin
          errors++; $display("FAIL rnd_extra_write idx %0d data %h", seen, cap_data[seen]);
        end else begin
          if (cap_data[seen] !== exp_w[seen] || cap_addr[seen] != (seen % 64)) begin
            errors++;
            $display("FAIL rnd_write idx %0d got %0d/%h want %0d/%h", seen, cap_addr[seen], cap_data[seen], seen % 64, exp_w[seen]);
          end
          if (!exp_p[seen]) popped++;
        end
        seen++;
      end
      checks++;
      if (in_ready !== ((acc - popped) < DEPTH)) begin
        errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, in_ready, (acc - popped) < DEPTH);
      end
      in_valid = ($urandom_range(0, 99) < 60);
      m  = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11);
      s  = $urandom_range(0, 31); t = $urandom_range(0, 31); d = $urandom_range(0, 31);
      im = $urandom_range(0, 65535); tg = $urandom_range(0, (1 << 26) - 1);
      mnem = 4'(m); rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = 16'(im); target = 26'(tg);
      mem_ready = ($urandom_range(0, 99) < 65);
      if (in_valid && in_ready) begin
        if (m < 12) begin
          exp_w.push_back(ref_word(m, s, t, d, im, tg));
          exp_p.push_back(1'b0);
          acc++;
`ifdef DELAY_SLOT_PAD_EN
          if (m == 7 || m == 11) begin
            exp_w.push_back(32'h0);
            exp_p.push_back(1'b1);
          end
`endif
        end else begin
          any_bad = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    while (cap_data.size() < exp_w.size() && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    while (seen < cap_data.size()) begin
      checks++;
      if (seen >= exp_w.size()) begin
        errors++; $display("FAIL rnd_extra_write idx %0d data %h", seen, cap_data[seen]);
      end else if (cap_data[seen] !== exp_w[seen] || cap_addr[seen] != (seen % 64)) begin
        errors++;
        $display("FAIL rnd_write idx %0d got %0d/%h want %0d/%h", seen, cap_addr[seen], cap_data[seen], seen % 64, exp_w[seen]);
      end
      seen++;
    end
    checks++;
    if (cap_data.size() != exp_w.size()) begin
      errors++; $display("FAIL rnd_total got %0d want %0d", cap_data.size(), exp_w.size());
    end
    checks++; if (err !== any_bad) begin errors++; $display("FAIL rnd_err got %b want %b", err, any_bad); end
    checks++;
    if (wr_count !== 16'(exp_w.size())) begin
      errors++; $display("FAIL rnd_wr_count got %0d want %0d", wr_count, exp_w.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_stall();
    test_full();
    test_back_to_back();
    test_branch();
    test_err();
    test_wrap_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
